// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Purpose  : Parameterised ripple-carry adder built from 1-bit full-adder
//            cells. Offers a zero-latency combinational sum/carry and a
//            one-cycle registered copy qualified by out_valid.
// Options  : FULL_ADDER_OVF_EN adds signed-overflow outputs ovf / ovf_q.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
  output logic             ovf_q,
`endif
  output logic             out_valid
);

  // Carry chain: w_k[0] is the carry into bit 0, w_k[WIDTH] the carry out.
  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_s;

  assign w_k[0] = carry_in;

  // One full-adder cell per bit; carries ripple from LSB to MSB.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign w_s[i]   = a[i] ^ b[i] ^ w_k[i];
      assign w_k[i+1] = (a[i] & b[i]) | (a[i] & w_k[i]) | (b[i] & w_k[i]);
    end
  endgenerate

  assign c         = w_s;
  assign carry_out = w_k[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = w_k[WIDTH] ^ w_k[WIDTH-1];
  assign ovf   = w_ovf;
  assign ovf_q = r_ovf;

  // Overflow flag captured alongside the registered carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_ovf;
    end
  end
`endif

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_valid;

  // Capture the combinational result when qualified; hold it otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else if (in_valid) begin
      r_sum   <= w_s;
      r_carry <= w_k[WIDTH];
    end
  end

  // Valid strobe trails the input qualifier by exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
    end
  end

  assign sum_q     = r_sum;
  assign carry_q   = r_carry;
  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder
// Purpose  : Self-checking bench for full_adder (WIDTH=1 and WIDTH=8 copies).
//            Registered results are checked through an expected-value queue
//            drained by a monitor whenever out_valid is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_full_adder;

`ifdef FULL_ADDER_OVF_EN
  localparam bit c_ovf = 1'b1;
`else
  localparam bit c_ovf = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // WIDTH=1 instance signals
  logic a1, b1, ci1, iv1;
  logic c1, co1, sq1, cq1, ov1;
  // WIDTH=8 instance signals
  logic [7:0] a8, b8, c8, sq8;
  logic       ci8, iv8, co8, cq8, ov8;
  logic       ovf8, ovfq8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovfq1;
`endif

  int checks = 0;
  int errors = 0;

  // Expected registered result: {ovf, carry, sum}
  logic [9:0] exp_q[$];
  logic [9:0] last_q;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(ci1), .in_valid(iv1),
    .c(c1), .carry_out(co1), .sum_q(sq1), .carry_q(cq1),
`ifdef FULL_ADDER_OVF_EN
    .ovf(ovf1), .ovf_q(ovfq1),
`endif
    .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(ci8), .in_valid(iv8),
    .c(c8), .carry_out(co8), .sum_q(sq8), .carry_q(cq8),
`ifdef FULL_ADDER_OVF_EN
    .ovf(ovf8), .ovf_q(ovfq8),
`endif
    .out_valid(ov8)
  );

`ifndef FULL_ADDER_OVF_EN
  assign ovf8  = 1'b0;
  assign ovfq8 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare when out_valid is high, otherwise the
  // registered outputs must hold the last captured value.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q = '0;
    end else if (ov8) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got sum_q=%h with no expected entry", sq8);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("registered_result", {6'd0, ovfq8, cq8, sq8}, {6'd0, e});
        last_q = {ovfq8, cq8, sq8};
      end
    end else begin
      check("registered_hold", {6'd0, ovfq8, cq8, sq8}, {6'd0, last_q});
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec8_t;

  vec8_t v8[7] = '{
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
    '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
    '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  // Hand-computed 1-bit truth table, index = {a,b,ci}, value = {co,s}
  logic [1:0] tt1[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a1 = 0; b1 = 0; ci1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; ci8 = 0; iv8 = 0;
    last_q = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_sum_q", {8'd0, sq8}, 16'h0000);
    check("reset_carry_q", {15'd0, cq8}, 16'h0000);
    check("reset_out_valid", {15'd0, ov8}, 16'h0000);
    check("reset_ovf_q", {15'd0, ovfq8}, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed 1-bit vectors from the plan
    a1 = 0; b1 = 0; ci1 = 0; #1;
    check("w1_000", {14'd0, co1, c1}, 16'h0000);
    ci1 = 1; #1;
    check("w1_001", {14'd0, co1, c1}, 16'h0001);
    a1 = 1; b1 = 1; ci1 = 1; #1;
    check("w1_111", {14'd0, co1, c1}, 16'h0003);
    ci1 = 0; #1;
    check("w1_110", {14'd0, co1, c1}, 16'h0002);
    // Exhaustive 1-bit sweep
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      {a1, b1, ci1} = idx;
      #1;
      check($sformatf("w1_sweep_%0d", i), {14'd0, co1, c1}, {14'd0, tt1[i]});
    end

    // 8-bit vectors issued back to back through the registered stage
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      a8 = v8[i].a; b8 = v8[i].b; ci8 = v8[i].ci; iv8 = 1'b1;
      exp_q.push_back({v8[i].ov & c_ovf, v8[i].co, v8[i].s});
      #1;
      check($sformatf("w8_comb_%0d", i), {7'd0, co8, c8}, {7'd0, v8[i].co, v8[i].s});
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w8_ovf_%0d", i), {15'd0, ovf8}, {15'd0, v8[i].ov});
`endif
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation
    a8 = 8'h12; b8 = 8'h34; ci8 = 0; iv8 = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_sum_q", {8'd0, sq8}, 16'h0046);
    check("pre_reset_valid", {15'd0, ov8}, 16'h0001);
    a8 = 8'h01; b8 = 8'h02;          // pending capture, to be discarded
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_sum_q", {8'd0, sq8}, 16'h0000);
    check("async_reset_carry_q", {15'd0, cq8}, 16'h0000);
    check("async_reset_out_valid", {15'd0, ov8}, 16'h0000);
    @(posedge clk); #1;              // edge under reset with in_valid high
    check("reset_hold_sum_q", {8'd0, sq8}, 16'h0000);
    iv8 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_release_idle", {15'd0, ov8}, 16'h0000);
    iv8 = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    @(posedge clk); #1;
    check("first_capture_valid", {15'd0, ov8}, 16'h0001);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
